ysyx_multiport_regfile: RTL and testbench
=========================================

# ysyx_multiport_regfile

Parametrised general-purpose register file for the ysyx core, successor to the single-write, two-read file. It adds configurable width, depth and read-port count, a second write port, same-cycle write-to-read bypass, hardwired-zero x0, a per-register busy scoreboard for in-flight writes, and a post-reset clear sequencer. It sits between decode (reads, reservations) and writeback (writes, releases).

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: register count; power of two, at least 2.
- NRD, 2: read-port count, 1..4.
- AW, $clog2(NREG): address width; derived, not overridden.
- clk  in  1  clock; every sequential element uses its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  high once the clear sequence has finished.
- we0, we1  in  1 each  write enables.
- waddr0, waddr1  in  AW each  write addresses.
- wdata0, wdata1  in  XLEN each  write data.
- raddr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data.
- rsv_en  in  1  mark rsv_addr busy because a write is in flight.
- rsv_addr  in  AW  register to reserve.
- busy  out  NRD  busy flag for each read port's address.

## Operation
- Reset: asserting rst clears the scoreboard, sets ready=0 and starts the clear FSM in CLEAR with clr_idx=0.
- Clear FSM:
  - CLEAR writes zero to entry clr_idx each cycle and increments clr_idx.
  - After writing entry NREG-1, go to RUN. ready=1 only in RUN.
  - In CLEAR, we0, we1 and rsv_en are ignored, rdata reads 0 and busy reads 0.
  - If rst is asserted again during CLEAR, the FSM restarts at clr_idx=0.
- Writes in RUN:
  - A write to address 0 is discarded.
  - If both ports are enabled and waddr0==waddr1, port 1 wins.
- Reads (combinational):
  - Address 0 returns 0.
  - Otherwise, if a write enabled this cycle targets the same address, return its wdata (port 1 has priority over port 0).
  - Otherwise return the stored value.
- Scoreboard, one bit per register, bit 0 tied to 0:
  - rsv_en sets bit rsv_addr.
  - An enabled write clears bit waddr.
  - If reserve and write hit the same register in the same cycle, reserve wins and the bit stays set.
  - Reserving an already-busy register leaves it set. No counting of outstanding writes.
- busy[i] is the registered bit for raddr port i. It is not bypassed: a write in the current cycle does not clear busy until the next cycle.

## Timing
- Reset values: ready=0, busy=0, rdata=0.
- Clear takes exactly NREG cycles after rst deasserts; ready rises on edge NREG.
- Write latency: the data is visible in storage one cycle after the edge. Because of the bypass, rdata shows the new value in the same cycle as the write.
- Scoreboard updates take effect on the clock edge; busy reflects the new state the following cycle.
- There are no handshakes or stalls. The caller must not issue writes before ready is high; such writes are dropped.

## Structure
- A shared package ysyx_rf_pkg holds the FSM state enum (CLEAR, RUN) and the default XLEN/NREG constants, so decode and writeback use the same values.
- One sub-module: ysyx_rf_scoreboard, which holds the NREG-bit busy vector, reserve/release priority and read-out muxes. Storage, bypass and the clear FSM stay in the top module.
- Storage is an unreset array, which keeps it RAM-friendly; the clear FSM provides the architectural zero state.

## Test plan
- Reset then idle: ready stays 0 for 32 cycles and rises on cycle 32. Reading every register then returns 0.
- Write 0xDEADBEEF to x5 on port 0: rdata for x5 equals 0xDEADBEEF in the same cycle and afterwards. A write of 0x1234 to x0 still reads 0.
- Same-cycle collision: port 0 writes x7=0x11 and port 1 writes x7=0x22. Bypass shows 0x22, and the next cycle reads 0x22.
- Scoreboard: reserve x9, next cycle busy=1. Write x9 together with rsv_en on x9: busy stays 1. Write x9 alone: busy returns to 0 the cycle after.
- Reset mid-clear at cycle 10: ready stays 0, and the count restarts so ready rises 32 cycles after the second deassertion. Writes attempted during CLEAR are dropped and read back as 0.
- Parameter sweep XLEN=64, NREG=16, NRD=3: all three ports read independent addresses correctly, and clear takes 16 cycles.

Source files
------------

// File: rtl/ysyx_rf_pkg.sv
// Shared register-file definitions: default sizing and the clear-sequencer state type.
// Decode and writeback import this so they size against the same constants.
package ysyx_rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/ysyx_rf_scoreboard.sv
// Per-register busy bits for in-flight writes; reservation beats a same-cycle release.
// Busy outputs are the registered bits, deliberately not bypassed.
module ysyx_rf_scoreboard #(
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_run,
  input  logic            i_rsv_en,
  input  logic [AW-1:0]   i_rsv_addr,
  input  logic            i_we0,
  input  logic [AW-1:0]   i_waddr0,
  input  logic            i_we1,
  input  logic [AW-1:0]   i_waddr1,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD-1:0]  o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_run) begin
      if (i_we0)    w_busy_nxt[i_waddr0]   = 1'b0;
      if (i_we1)    w_busy_nxt[i_waddr1]   = 1'b0;
      if (i_rsv_en) w_busy_nxt[i_rsv_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] w_ra;
    assign w_ra      = i_raddr[i*AW +: AW];
    assign o_busy[i] = i_run & r_busy[w_ra];
  end

endmodule

// File: rtl/ysyx_multiport_regfile.sv
// Two-write, NRD-read register file with write-to-read bypass, hardwired x0,
// a busy scoreboard and a post-reset sequencer that zeroes the unreset storage.
module ysyx_multiport_regfile
  import ysyx_rf_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr0,
  input  logic [AW-1:0]     waddr1,
  input  logic [XLEN-1:0]   wdata0,
  input  logic [XLEN-1:0]   wdata1,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NRD-1:0]    busy
);

  rf_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_clr_idx, w_clr_idx_nxt;
  logic          w_run;
  logic          w_wen0, w_wen1;

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    if (r_state == CLEAR) begin
      w_clr_idx_nxt = r_clr_idx + AW'(1);
      if (r_clr_idx == AW'(NREG - 1)) w_state_nxt = RUN;
    end
  end

  assign w_run  = (r_state == RUN);
  assign ready  = w_run;
  assign w_wen0 = w_run && we0 && (waddr0 != '0);
  assign w_wen1 = w_run && we1 && (waddr1 != '0);

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      if (w_wen0) r_mem[waddr0] <= wdata0;
      if (w_wen1) r_mem[waddr1] <= wdata1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;

    assign w_ra = raddr[i*AW +: AW];

    always_comb begin
      w_rd = '0;
      if (w_run && (w_ra != '0)) begin
        if (w_wen1 && (waddr1 == w_ra))      w_rd = wdata1;
        else if (w_wen0 && (waddr0 == w_ra)) w_rd = wdata0;
        else                                 w_rd = r_mem[w_ra];
      end
    end

    assign rdata[i*XLEN +: XLEN] = w_rd;
  end

  ysyx_rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .i_we0      (we0),
    .i_waddr0   (waddr0),
    .i_we1      (we1),
    .i_waddr1   (waddr1),
    .i_raddr    (raddr),
    .o_busy     (busy)
  );

endmodule

// File: tb/tb_ysyx_multiport_regfile.sv
// Lockstep bench for two instances (32x32/2 ports and 64x16/3 ports) sharing one stimulus;
// expectations are queued from an array model and compared by a negedge monitor.
module tb_ysyx_multiport_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we0, we1, rsv_en;
  logic [4:0]  wa0, wa1, rsva;
  logic [63:0] wd0, wd1;
  logic [4:0]  ra [3];

  logic         rdy_a, rdy_b;
  logic [63:0]  rd_a;
  logic [191:0] rd_b;
  logic [1:0]   bz_a;
  logic [2:0]   bz_b;

  always #5 clk = ~clk;

  ysyx_multiport_regfile #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (
    .clk(clk), .rst(rst), .ready(rdy_a),
    .we0(we0), .we1(we1), .waddr0(wa0), .waddr1(wa1),
    .wdata0(wd0[31:0]), .wdata1(wd1[31:0]),
    .raddr({ra[1], ra[0]}), .rdata(rd_a),
    .rsv_en(rsv_en), .rsv_addr(rsva), .busy(bz_a)
  );

  ysyx_multiport_regfile #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
    .clk(clk), .rst(rst), .ready(rdy_b),
    .we0(we0), .we1(we1), .waddr0(wa0[3:0]), .waddr1(wa1[3:0]),
    .wdata0(wd0), .wdata1(wd1),
    .raddr({ra[2][3:0], ra[1][3:0], ra[0][3:0]}), .rdata(rd_b),
    .rsv_en(rsv_en), .rsv_addr(rsva[3:0]), .busy(bz_b)
  );

  typedef struct {
    int          d;
    int          kind;
    int          port;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural contents, busy bits and edges since reset release.
  logic [63:0] m_mem [2][32];
  bit          m_bz  [2][32];
  int          m_cnt [2];

  function automatic int nreg_of(int d); return (d != 0) ? 16 : 32; endfunction
  function automatic int nrd_of(int d);  return (d != 0) ? 3 : 2;   endfunction
  function automatic logic [63:0] msk(int d, logic [63:0] v);
    return (d != 0) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int n;
      int a;
      bit rdy;
      logic [63:0] e;
      n = nreg_of(d);
      if (rst) begin
        m_cnt[d] = 0;
        for (int k = 0; k < 32; k++) m_bz[d][k] = 1'b0;
      end
      rdy = (m_cnt[d] >= n);
      q.push_back('{d, 0, 0, {63'd0, rdy}});
      for (int p = 0; p < nrd_of(d); p++) begin
        a = int'(ra[p]) % n;
        if (!rdy || a == 0)                       e = '0;
        else if (we1 && (int'(wa1) % n) == a)      e = msk(d, wd1);
        else if (we0 && (int'(wa0) % n) == a)      e = msk(d, wd0);
        else                                      e = m_mem[d][a];
        q.push_back('{d, 1, p, e});
        q.push_back('{d, 2, p, {63'd0, rdy && m_bz[d][a]}});
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int n;
      int a0, a1, ar;
      n  = nreg_of(d);
      a0 = int'(wa0) % n;
      a1 = int'(wa1) % n;
      ar = int'(rsva) % n;
      if (rst) begin
        m_cnt[d] = 0;
      end else if (m_cnt[d] < n) begin
        m_cnt[d]++;
        if (m_cnt[d] == n)
          for (int k = 0; k < 32; k++) m_mem[d][k] = '0;
      end else begin
        if (we0 && a0 != 0) begin m_mem[d][a0] = msk(d, wd0); m_bz[d][a0] = 1'b0; end
        if (we1 && a1 != 0) begin m_mem[d][a1] = msk(d, wd1); m_bz[d][a1] = 1'b0; end
        if (rsv_en && ar != 0) m_bz[d][ar] = 1'b1;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    string       nm;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0: begin nm = "ready"; act = {63'd0, (e.d != 0) ? rdy_b : rdy_a}; end
        1: begin
          nm  = "rdata";
          act = (e.d != 0) ? rd_b[e.port*64 +: 64] : {32'd0, rd_a[e.port*32 +: 32]};
        end
        default: begin
          nm  = "busy";
          act = {63'd0, (e.d != 0) ? bz_b[e.port] : bz_a[e.port]};
        end
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d port%0d t=%0t: got %h expected %h",
                 nm, e.d, e.port, $time, act, e.val);
      end
    end
  end

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = 0; wa1 = 0; rsva = 0; wd0 = 0; wd1 = 0;
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] set [4];
    set[0] = 5'd0; set[1] = 5'd1; set[2] = 5'd5; set[3] = 5'd9;
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
    return set[$urandom_range(0, 3)];
  endfunction

  task automatic rnd_in();
    we0    = 1'($urandom_range(0, 1));
    we1    = 1'($urandom_range(0, 1));
    rsv_en = 1'($urandom_range(0, 1));
    wa0    = pick_addr();
    wa1    = pick_addr();
    rsva   = pick_addr();
    wd0    = {$urandom, $urandom};
    wd1    = {$urandom, $urandom};
    for (int p = 0; p < 3; p++) begin
      case ($urandom_range(0, 3))
        0:       ra[p] = wa0;
        1:       ra[p] = wa1;
        2:       ra[p] = rsva;
        default: ra[p] = pick_addr();
      endcase
    end
  endtask

  initial begin
    idle();
    for (int p = 0; p < 3; p++) ra[p] = 5'($urandom_range(0, 31));
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      for (int k = 0; k < 32; k++) begin m_mem[d][k] = '0; m_bz[d][k] = 1'b0; end
    end
    #2;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin rnd_in(); tick(); end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin rnd_in(); tick(); end

    for (int i = 0; i < 32; i++) begin
      idle();
      ra[0] = 5'(i); ra[1] = 5'(31 - i); ra[2] = 5'(i);
      tick();
    end

    idle(); we0 = 1; wa0 = 5; wd0 = 64'h0000_0000_DEAD_BEEF; ra[0] = 5; ra[1] = 5; tick();
    idle(); ra[0] = 5; tick();
    idle(); we0 = 1; wa0 = 0; wd0 = 64'h1234; ra[0] = 0; tick();
    idle(); ra[0] = 0; tick();

    idle(); we0 = 1; wa0 = 7; wd0 = 64'h11; we1 = 1; wa1 = 7; wd1 = 64'h22;
    ra[0] = 7; ra[1] = 7; ra[2] = 7; tick();
    idle(); tick();

    idle(); rsv_en = 1; rsva = 9; ra[0] = 9; ra[1] = 9; ra[2] = 9; tick();
    idle(); tick();
    idle(); we0 = 1; wa0 = 9; wd0 = 64'h99; rsv_en = 1; rsva = 9; tick();
    idle(); tick();
    idle(); we1 = 1; wa1 = 9; wd1 = 64'h98; tick();
    idle(); tick();
    idle(); tick();

    for (int i = 0; i < 400; i++) begin rnd_in(); tick(); end

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
